// File: rtl/ccff_chain_loader.sv
// Shifts a word-serial host bitstream MSB-first into the config chain (load), or recirculates tail->head and compares (verify).
// Registered controls, one bit per cycle; s_ready holds off the host whenever the word buffer still has bits left to shift.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 36,
  parameter int WORD_W    = 8
) (
  input  logic                           prog_clk,
  input  logic                           pReset,
  input  logic                           cmd_load,
  input  logic                           cmd_verify,
  input  logic [WORD_W-1:0]              s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic                           ccff_head,
  output logic                           ccff_clk_en,
  input  logic                           ccff_tail,
  output logic                           busy,
  output logic                           done,
  output logic                           verify_err,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int IW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LEN_C  = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] LEN_M1 = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CNT_1  = CW'(1);
  localparam logic [IW-1:0] WORD_C = IW'(WORD_W);
  localparam logic [IW-1:0] IDX_1  = IW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, FINISH} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              head_q, head_d;
  logic              en_q, en_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              vmode_q, vmode_d;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_load || cmd_verify) begin
          state_d = cmd_load ? LOAD : VERIFY;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD, VERIFY: begin
        // en_q marks this cycle as a shift of the buffer MSB (idx_q counts bits still unshifted)
        if (en_q) begin
          buf_d = buf_q << 1;
          idx_d = idx_q - IDX_1;
          cnt_d = cnt_q + CNT_1;
          if (state_q == VERIFY && ccff_tail != buf_q[WORD_W-1]) begin
            err_d = 1'b1;
          end
        end
        if (s_valid && rdy_q) begin
          buf_d = s_data;
          idx_d = WORD_C;
        end
        if (cnt_d == LEN_C) begin
          state_d = FINISH;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == LOAD) || (state_d == VERIFY);
    vmode_d = (state_d == VERIFY);
    en_d    = busy_d && (idx_d != '0) && (cnt_d < LEN_C);
    if (en_d && state_d == LOAD) begin
      head_d = buf_d[WORD_W-1];
    end
    rdy_d  = busy_d && ((idx_d == '0) || (en_d && idx_d == IDX_1 && cnt_d < LEN_M1));
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      head_q  <= 1'b0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      vmode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      vmode_q <= vmode_d;
    end
  end

  // Recirculation must be a wire: a flop in the loop would make it CHAIN_LEN+1 long and rotate the contents.
  assign ccff_head   = vmode_q ? ccff_tail : head_q;
  assign ccff_clk_en = en_q;
  assign s_ready     = rdy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign verify_err  = err_q;
  assign bit_cnt     = cnt_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: drives directed and random passes against a behavioural chain model and bitstream reference.
module tb_ccff_chain_loader;

  localparam int LEN = 36;
  localparam int W   = 8;
  localparam int NW  = (LEN + W - 1) / W;
  localparam int CW  = $clog2(LEN + 1);

  logic          prog_clk = 1'b0;
  logic          pReset = 1'b1;
  logic          cmd_load = 1'b0;
  logic          cmd_verify = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, ccff_head, ccff_clk_en, ccff_tail, busy, done, verify_err;
  logic [CW-1:0] bit_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(LEN), .WORD_W(W)) dut (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .cmd_load   (cmd_load),
    .cmd_verify (cmd_verify),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .ccff_head  (ccff_head),
    .ccff_clk_en(ccff_clk_en),
    .ccff_tail  (ccff_tail),
    .busy       (busy),
    .done       (done),
    .verify_err (verify_err),
    .bit_cnt    (bit_cnt)
  );

  // Chain model: head enters at bit 0, tail leaves from bit LEN-1; clocked by the gated clock.
  logic [LEN-1:0] chain = '0;
  logic           head_s = 1'b0;
  logic           en_s = 1'b0;
  int             cyc = 0;
  assign ccff_tail = chain[LEN-1];

  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (en_s) chain <= {chain[LEN-2:0], head_s};
  end

  int             n_en = 0, n_done = 0, n_shift = 0;
  int             done_cyc = -1, err_rise = -1, first_en = -1, last_en = -1;
  bit             done_busy = 1'b0;
  logic [LEN-1:0] seen = '0;

  always @(negedge prog_clk) begin
    head_s = ccff_head;
    en_s   = ccff_clk_en;
    if (verify_err && err_rise < 0) err_rise = n_shift;
    if (ccff_clk_en) begin
      n_en++;
      n_shift++;
      seen = {seen[LEN-2:0], ccff_head};
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc  = cyc;
      done_busy = busy;
    end
  end

  logic [W-1:0]   words [NW];
  int             gaps [NW];
  int             cmd_c, gap_sum, n_en0, n_done0;
  logic [LEN-1:0] old_chain;

  task automatic tick;
    @(negedge prog_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected bit sequence: words MSB-first, truncated to LEN bits; first bit lands in the MSB.
  function automatic logic [LEN-1:0] stream_vec();
    logic [LEN-1:0] v;
    v = '0;
    for (int k = 0; k < LEN; k++) v[LEN-1-k] = words[k/W][W-1-(k%W)];
    return v;
  endfunction

  task automatic send_word(input logic [W-1:0] w, input int gap, input bit poke);
    int t;
    t = 0;
    s_valid = 1'b0;
    while (!s_ready && t < 100) begin
      tick;
      t++;
    end
    chk("ready_wait", 64'(t < 100), 64'd1);
    repeat (gap) tick;
    s_data     = w;
    s_valid    = 1'b1;
    cmd_verify = poke;
    tick;
    cmd_verify = 1'b0;
  endtask

  task automatic run_pass(input bit ld, input bit vf, input bit poke);
    int t;
    n_shift  = 0;
    seen     = '0;
    err_rise = -1;
    done_cyc = -1;
    first_en = -1;
    last_en  = -1;
    n_en0    = n_en;
    n_done0  = n_done;
    gap_sum  = 0;
    for (int k = 0; k < NW; k++) gap_sum += gaps[k];
    old_chain  = chain;
    cmd_load   = ld;
    cmd_verify = vf;
    cmd_c      = cyc;
    tick;
    cmd_load   = 1'b0;
    cmd_verify = 1'b0;
    for (int k = 0; k < NW; k++) send_word(words[k], gaps[k], poke && k == 2);
    s_valid = 1'b0;
    t = 0;
    while (done_cyc < 0 && t < 300) begin
      tick;
      t++;
    end
  endtask

  task automatic check_pass(input logic [LEN-1:0] exp_seen, input logic [LEN-1:0] exp_chain,
                            input logic exp_err, input int exp_rise);
    chk("done_cycle", 64'(done_cyc), 64'(cmd_c + LEN + 2 + gap_sum));
    chk("busy_at_done", 64'(done_busy), 64'd0);
    chk("bit_cnt", 64'(bit_cnt), 64'(LEN));
    chk("clk_en_cycles", 64'(n_en - n_en0), 64'(LEN));
    chk("stall_cycles", 64'(last_en - first_en + 1 - LEN), 64'(gap_sum - gaps[0]));
    chk("head_seq", 64'(seen), 64'(exp_seen));
    chk("chain", 64'(chain), 64'(exp_chain));
    chk("verify_err", 64'(verify_err), 64'(exp_err));
    if (exp_err) chk("err_rise_shift", 64'(err_rise), 64'(exp_rise));
    chk("done_pulses", 64'(n_done - n_done0), 64'd1);
  endtask

  initial begin
    logic [LEN-1:0] pre, sv;
    int             fk, rise;
    logic           e;

    tick;
    tick;
    chk("reset_outputs", 64'({s_ready, ccff_head, ccff_clk_en, busy, done, verify_err, bit_cnt}), 64'd0);
    pReset = 1'b0;
    tick;

    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h90};
    gaps  = '{default: 0};
    run_pass(1'b1, 1'b0, 1'b0);
    check_pass(36'hA53CFF009, 36'hA53CFF009, 1'b0, 0);
    tick;

    gaps[2] = 3;
    run_pass(1'b1, 1'b0, 1'b0);
    check_pass(36'hA53CFF009, 36'hA53CFF009, 1'b0, 0);
    tick;

    gaps = '{default: 0};
    run_pass(1'b0, 1'b1, 1'b0);
    check_pass(36'hA53CFF009, 36'hA53CFF009, 1'b0, 0);
    tick;

    words[1] = 8'h3D;
    run_pass(1'b0, 1'b1, 1'b0);
    check_pass(36'hA53CFF009, 36'hA53CFF009, 1'b1, 16);
    tick;

    // Simultaneous commands: the chain must take the new stream, which verify would not do.
    for (int k = 0; k < NW; k++) words[k] = W'($urandom);
    words[0] = 8'h5A;
    run_pass(1'b1, 1'b1, 1'b0);
    sv = stream_vec();
    check_pass(sv, sv, 1'b0, 0);
    tick;

    for (int k = 0; k < NW; k++) words[k] = W'($urandom);
    run_pass(1'b1, 1'b0, 1'b1);
    sv = stream_vec();
    check_pass(sv, sv, 1'b0, 0);
    repeat (5) tick;
    chk("poke_busy_after", 64'(busy), 64'd0);
    chk("poke_no_extra_done", 64'(n_done - n_done0), 64'd1);

    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < NW; k++) begin
        words[k] = W'($urandom);
        gaps[k]  = int'($urandom_range(2));
      end
      run_pass(1'b1, 1'b0, 1'b0);
      sv = stream_vec();
      check_pass(sv, sv, 1'b0, 0);
      tick;
      if ($urandom_range(3) != 0) begin
        fk = int'($urandom_range(NW * W - 1));
        words[fk/W][W-1-(fk%W)] = ~words[fk/W][W-1-(fk%W)];
      end
      for (int k = 0; k < NW; k++) gaps[k] = int'($urandom_range(2));
      pre = chain;
      sv  = stream_vec();
      e   = (sv != pre);
      rise = 0;
      for (int k = LEN - 1; k >= 0; k--) if (sv[k] != pre[k] && rise == 0) rise = LEN - k;
      run_pass(1'b0, 1'b1, 1'b0);
      check_pass(pre, pre, e, rise);
      tick;
    end

    // Reset in the middle of a load, with the host still offering data afterwards.
    for (int k = 0; k < NW; k++) words[k] = W'($urandom);
    gaps = '{default: 0};
    cmd_load = 1'b1;
    tick;
    cmd_load = 1'b0;
    send_word(words[0], 0, 1'b0);
    send_word(words[1], 0, 1'b0);
    pReset = 1'b1;
    tick;
    chk("midpass_reset_outputs", 64'({s_ready, ccff_head, ccff_clk_en, busy, done, verify_err, bit_cnt}), 64'd0);
    tick;
    pReset = 1'b0;
    n_en0  = n_en;
    repeat (10) tick;
    chk("no_shift_after_reset", 64'(n_en - n_en0), 64'd0);
    chk("idle_after_reset", 64'({busy, s_ready}), 64'd0);
    s_valid = 1'b0;

    run_pass(1'b1, 1'b0, 1'b0);
    sv = stream_vec();
    check_pass(sv, sv, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain driver: the transmitting end of the `ccff_head` → `ccff_tail` scan chain that runs through the connection and switch blocks. The block takes a word-serial bitstream from the configuration host and shifts it MSB-first into `ccff_head`, gating the chain clock one bit at a time. In verify mode it recirculates `ccff_tail` back into `ccff_head`, which reads back every bit non-destructively and compares it against a second copy of the bitstream from the host. It sits at the fabric top, between the configuration host interface and the chain entry point.

## Interface
Parameters:
- `CHAIN_LEN`, 36 — total configuration flops in the chain (≥ 2).
- `WORD_W`, 8 — host word width (1..32).

Ports:
- `prog_clk` input 1 — configuration clock; the chain is clocked by the gated version of this clock.
- `pReset` input 1 — synchronous, active-high reset (decided fact).
- `cmd_load` input 1 — single-cycle pulse; starts a load pass.
- `cmd_verify` input 1 — single-cycle pulse; starts a verify pass.
- `s_data` input WORD_W — bitstream word, MSB-first.
- `s_valid` input 1 — `s_data` is valid.
- `s_ready` output 1 — word accepted when `s_valid` and `s_ready` are both high.
- `ccff_head` output 1 — bit presented to the chain head.
- `ccff_clk_en` output 1 — chain clock enable, fed to an external glitch-free clock gate on `prog_clk`.
- `ccff_tail` input 1 — chain tail output.
- `busy` output 1 — a pass is in progress.
- `done` output 1 — one-cycle pulse at the end of a pass.
- `verify_err` output 1 — sticky mismatch flag.
- `bit_cnt` output clog2(CHAIN_LEN+1) — number of bits shifted in the current or last pass.

## Operation
- States: IDLE, LOAD, VERIFY, FINISH.
- IDLE → LOAD on `cmd_load`. IDLE → VERIFY on `cmd_verify`.
  - If both commands arrive in the same cycle, LOAD wins.
  - Commands that arrive while `busy` is high are ignored.
- Entering LOAD or VERIFY:
  - `bit_cnt` is cleared to 0.
  - The word buffer is emptied.
  - `verify_err` is cleared.
- Word buffer:
  - Holds one WORD_W-bit shift register plus a bit index.
  - `s_ready` = `busy` AND (buffer empty OR the buffer's last bit is shifting this cycle AND `bit_cnt` < CHAIN_LEN−1). This allows back-to-back words with no bubble.
- Shift cycle: occurs when the buffer holds a bit and `bit_cnt` < CHAIN_LEN.
  - `ccff_clk_en` = 1.
  - LOAD: `ccff_head` = current buffer bit.
  - VERIFY: `ccff_head` = `ccff_tail`. `ccff_tail` is compared with the current buffer bit; any mismatch sets `verify_err`.
  - The buffer advances one bit and `bit_cnt` increments.
- Stall cycle: the buffer is empty and `s_valid` is low. `ccff_clk_en` = 0 and `ccff_head` holds its value. Stalls of any length are legal.
- Partial final word: CHAIN_LEN mod WORD_W ≠ 0 uses only the upper bits of the last word. The lower bits are discarded and are not compared.
- When `bit_cnt` reaches CHAIN_LEN: go to FINISH, assert `done` for one cycle, then return to IDLE. `busy` falls in the same cycle that `done` is asserted.
- Verify preserves chain contents, because exactly CHAIN_LEN recirculating shifts are performed.
- `pReset` mid-pass:
  - Returns the block to IDLE with all outputs at their reset values on the next edge.
  - Chain contents are then undefined; the host must reload.

## Timing
- All outputs are registered.
- Reset values: `s_ready`=0, `ccff_head`=0, `ccff_clk_en`=0, `busy`=0, `done`=0, `verify_err`=0, `bit_cnt`=0.
- Command latency:
  - A command sampled at edge N gives `busy`=1 from cycle N+1.
  - `s_ready` can rise in cycle N+1.
- First shift: a word accepted at edge M gives its MSB on `ccff_head` with `ccff_clk_en`=1 in cycle M+1.
- The chain captures `ccff_head` at the end of every cycle with `ccff_clk_en`=1.
- `ccff_tail` is sampled at that same edge, so it carries the value before the shift.
- Throughput: 1 bit per cycle with a continuous `s_valid`.
- Load pass duration with no stalls: CHAIN_LEN + 2 cycles from command to `done`.
- `verify_err` is updated at the edge following the mismatching shift. It holds until the next accepted command or reset.

## Test plan
- Reset: assert `pReset` for 2 cycles during an active LOAD. All outputs take their reset values next cycle, and `ccff_clk_en` is never high afterward until a new command.
- Load, CHAIN_LEN=36, WORD_W=8:
  - Stimulus: words 0xA5,0x3C,0xFF,0x00,0x90 with `s_valid` continuously high.
  - Required: 36 contiguous `ccff_clk_en` cycles; head sequence 10100101 00111100 11111111 00000000 1001; low nibble of 0x90 dropped; `done` at cycle 38; chain model matches.
- Stalls: same stream with `s_valid` dropped for 3 cycles mid-word 2. `ccff_clk_en` is low for exactly those 3 cycles, the bit order is unchanged, and `done` arrives 3 cycles later.
- Verify pass, matching data:
  - Stimulus: verify with the same stream after a load.
  - Required: `verify_err`=0, chain model unchanged after `done`, `bit_cnt`=36.
- Verify pass, mismatch: verify with word 2 = 0x3D instead of 0x3C. `verify_err` rises after shift 16, stays high, and the chain model is still unchanged.
- Command rules:
  - `cmd_load` and `cmd_verify` in the same cycle → LOAD runs.
  - `cmd_verify` pulsed while `busy` is high → ignored; no extra `done`.
